// File: rtl/sw_event_scanner.sv
// Switch input conditioner: 2-FF synchroniser, per-channel debounce, press/release pulses
// and a prioritised, merge-on-overflow event register with a valid/ack handshake.
module sw_event_scanner #(
   parameter int N_SW            = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES),
   localparam int CODE_W = $clog2(N_SW) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SW-1:0]   sw,
   output logic [N_SW-1:0]   sw_level,
   output logic [N_SW-1:0]   press,
   output logic [N_SW-1:0]   release_pulse,
   output logic              evt_valid,
   output logic [CODE_W-1:0] evt_code,
   input  logic              evt_ack,
   output logic              overflow
);

   localparam int N_PEND = 2 * N_SW;

   logic [N_SW-1:0]            sync1_d, sync1_q;
   logic [N_SW-1:0]            sync2_d, sync2_q;
   logic [N_SW-1:0][CNT_W-1:0] cnt_d, cnt_q;
   logic [N_SW-1:0]            level_d, level_q;
   logic [N_SW-1:0]            press_d, press_q;
   logic [N_SW-1:0]            rel_d, rel_q;
   logic [N_PEND-1:0]          pend_d, pend_q;
   logic                       evt_valid_d, evt_valid_q;
   logic [CODE_W-1:0]          evt_code_d, evt_code_q;
   logic                       overflow_d, overflow_q;

   logic                       load;
   logic                       found;
   logic [CODE_W-1:0]          sel_idx;
   logic [N_PEND-1:0]          set_v;
   logic [N_PEND-1:0]          clr_v;

   always_comb begin
      sync1_d = sw;
      sync2_d = sync1_q;
      for (int unsigned i = 0; i < N_SW; i++) begin
         cnt_d[i]   = '0;
         level_d[i] = level_q[i];
         press_d[i] = 1'b0;
         rel_d[i]   = 1'b0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync2_q[i];
               press_d[i] = sync2_q[i];
               rel_d[i]   = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Pending bit 2*i is ch i press, 2*i+1 its release; lowest index wins, and its
   // event code is simply the bit index with the low bit inverted.
   always_comb begin
      load    = ~evt_valid_q | evt_ack;
      set_v   = '0;
      clr_v   = '0;
      found   = 1'b0;
      sel_idx = '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
         set_v[2*i]     = press_q[i];
         set_v[2*i + 1] = rel_q[i];
      end
      if (load) begin
         for (int unsigned k = 0; k < N_PEND; k++) begin
            if (!found && pend_q[k]) begin
               found    = 1'b1;
               clr_v[k] = 1'b1;
               sel_idx  = CODE_W'(k);
            end
         end
      end
      evt_valid_d = load ? found : evt_valid_q;
      evt_code_d  = (load && found) ? (sel_idx ^ CODE_W'(1)) : evt_code_q;
      pend_d      = (pend_q & ~clr_v) | set_v;
      overflow_d  = overflow_q | (|(set_v & pend_q & ~clr_v));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         cnt_q       <= '0;
         level_q     <= '0;
         press_q     <= '0;
         rel_q       <= '0;
         pend_q      <= '0;
         evt_valid_q <= 1'b0;
         evt_code_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         pend_q      <= pend_d;
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         overflow_q  <= overflow_d;
      end
   end

   assign sw_level      = level_q;
   assign press         = press_q;
   assign release_pulse = rel_q;
   assign evt_valid     = evt_valid_q;
   assign evt_code      = evt_code_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_sw_event_scanner.sv
// Directed and randomized bench for sw_event_scanner against a window-based behavioural model.
module tb_sw_event_scanner;

   localparam int N = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] sw;
   logic [N-1:0] sw_level;
   logic [N-1:0] press;
   logic [N-1:0] release_pulse;
   logic         evt_valid;
   logic [2:0]   evt_code;
   logic         evt_ack;
   logic         overflow;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference state: h[0] is the newest pin sample, h[1..D] the debounce window.
   logic [N-1:0] h [0:D];
   logic [N-1:0] m_level, m_press, m_rel;
   logic [2*N-1:0] m_pend;
   logic         m_valid;
   logic [2:0]   m_code;
   logic         m_ovf;

   sw_event_scanner #(.N_SW(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sw           (sw),
      .sw_level     (sw_level),
      .press        (press),
      .release_pulse(release_pulse),
      .evt_valid    (evt_valid),
      .evt_code     (evt_code),
      .evt_ack      (evt_ack),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge using the inputs held before that edge.
   task automatic model_edge();
      logic [2*N-1:0] set_v;
      int ld;
      logic all_diff;
      if (!rst_n) begin
         for (int j = 0; j <= D; j++) h[j] = '0;
         m_level = '0; m_press = '0; m_rel = '0;
         m_pend = '0; m_valid = 1'b0; m_code = '0; m_ovf = 1'b0;
      end else begin
         for (int c = 0; c < N; c++) begin
            set_v[2*c]   = m_press[c];
            set_v[2*c+1] = m_rel[c];
         end
         if (!m_valid || evt_ack) begin
            ld = -1;
            for (int k = 0; k < 2*N; k++) if (ld < 0 && m_pend[k]) ld = k;
            m_valid = (ld >= 0);
            if (ld >= 0) begin
               m_code     = 3'(ld ^ 1);
               m_pend[ld] = 1'b0;
            end
         end
         for (int k = 0; k < 2*N; k++) begin
            if (set_v[k]) begin
               if (m_pend[k]) m_ovf = 1'b1;
               m_pend[k] = 1'b1;
            end
         end
         for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++) if (h[j][c] == m_level[c]) all_diff = 1'b0;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (all_diff) begin
               m_level[c] = ~m_level[c];
               m_press[c] = m_level[c];
               m_rel[c]   = ~m_level[c];
            end
         end
         for (int j = D; j > 0; j--) h[j] = h[j-1];
         h[0] = sw;
      end
   endtask

   task automatic compare();
      chk("sw_level", 32'(sw_level), 32'(m_level));
      chk("press", 32'(press), 32'(m_press));
      chk("release", 32'(release_pulse), 32'(m_rel));
      chk("evt_valid", 32'(evt_valid), 32'(m_valid));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) chk("evt_code", 32'(evt_code), 32'(m_code));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      compare();
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 1'b0; sw = '0; evt_ack = 1'b0;
      for (int j = 0; j <= D; j++) h[j] = '0;
      m_level = '0; m_press = '0; m_rel = '0;
      m_pend = '0; m_valid = 1'b0; m_code = '0; m_ovf = 1'b0;

      // Reset and press latency
      hold(3);
      chk("rst_code", 32'(evt_code), 32'd0);
      chk("rst_level", 32'(sw_level), 32'd0);
      rst_n = 1'b1;
      while (cyc < 9) step();
      sw[0] = 1'b1;
      hold(5);
      chk("lat_before", 32'(sw_level[0]), 32'd0);
      step();
      chk("lat_rise", 32'(sw_level[0]), 32'd1);
      chk("lat_press", 32'(press[0]), 32'd1);
      step();
      chk("lat_press_end", 32'(press[0]), 32'd0);
      chk("lat_valid_wait", 32'(evt_valid), 32'd0);
      step();
      chk("lat_valid", 32'(evt_valid), 32'd1);
      chk("lat_code", 32'(evt_code), 32'b001);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
      chk("lat_ack", 32'(evt_valid), 32'd0);

      // Glitch filter, then a just-long-enough pulse
      sw[1] = 1'b1; hold(3); sw[1] = 1'b0; hold(10);
      chk("glitch_level", 32'(sw_level[1]), 32'd0);
      chk("glitch_valid", 32'(evt_valid), 32'd0);
      sw[1] = 1'b1; hold(4); sw[1] = 1'b0; hold(12);
      chk("pulse_code1", 32'(evt_code), 32'b011);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
      chk("pulse_code2", 32'(evt_code), 32'b010);
      chk("pulse_valid2", 32'(evt_valid), 32'd1);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
      chk("pulse_drained", 32'(evt_valid), 32'd0);

      // Simultaneous presses on ch2 and ch3
      sw[3:2] = 2'b11; hold(10);
      chk("simul_code1", 32'(evt_code), 32'b101);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
      chk("simul_valid", 32'(evt_valid), 32'd1);
      chk("simul_code2", 32'(evt_code), 32'b111);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
      chk("simul_drained", 32'(evt_valid), 32'd0);

      // Overflow on ch0 with ack held low
      sw[0] = 1'b0; hold(8);
      evt_ack = 1'b1; hold(2); evt_ack = 1'b0;
      chk("ovf_pre", 32'(overflow), 32'd0);
      for (int r = 0; r < 2; r++) begin
         sw[0] = 1'b1; hold(7);
         sw[0] = 1'b0; hold(7);
      end
      sw[0] = 1'b1; hold(8);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_code", 32'(evt_code), 32'b001);
      evt_ack = 1'b1; hold(4); evt_ack = 1'b0; hold(2);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-count on ch1
      sw = 4'b0010; hold(3);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      chk("mid_rst_valid", 32'(evt_valid), 32'd0);
      chk("mid_rst_level", 32'(sw_level), 32'd0);
      hold(5);
      chk("mid_rst_wait", 32'(sw_level[1]), 32'd0);
      step();
      chk("mid_rst_rise", 32'(sw_level[1]), 32'd1);

      // Stray ack while empty, then a normal press
      evt_ack = 1'b1; hold(3); evt_ack = 1'b0; step();
      chk("stray_pre", 32'(evt_valid), 32'd0);
      evt_ack = 1'b1; step(); evt_ack = 1'b0; step();
      chk("stray_valid", 32'(evt_valid), 32'd0);
      chk("stray_ovf", 32'(overflow), 32'd0);
      sw[2] = 1'b1; hold(8);
      chk("stray_code", 32'(evt_code), 32'b101);

      // Randomized activity checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, N-1)] ^= 1'b1;
         evt_ack = ($urandom_range(0, 2) == 0);
         rst_n   = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_n = 1'b1; evt_ack = 1'b0;
      hold(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
